ritardo_stat: RTL and testbench

//  Downstream consumer of the delay-measurement unit's 8-bit result bus.

---
 rtl/ritardo_stat.sv | 155 +++++++++++++++
 tb/tb_ritardo_stat.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ritardo_stat.sv
// Window statistics over NCAMP delay samples: min, max and truncated mean, held under a valid/ack handshake.
// Optional drop counter enabled by defining RITARDO_STAT_DROP_EN.
module ritardo_stat #(
    parameter int W     = 8,
    parameter int LOG_N = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] dato,
    input  logic         dato_v,
    output logic [W-1:0] min_o,
    output logic [W-1:0] max_o,
    output logic [W-1:0] media_o,
    output logic         out_v,
    input  logic         ack,
`ifdef RITARDO_STAT_DROP_EN
    output logic [7:0]   drop_cnt,
`endif
    output logic         ovf
);

    localparam int NCAMP = 1 << LOG_N;
    localparam int SW    = W + LOG_N;
    localparam logic [LOG_N-1:0] LAST = LOG_N'(NCAMP - 1);

    localparam logic S_ACC = 1'b0;
    localparam logic S_OUT = 1'b1;

    logic             state_q, state_d;
    logic [LOG_N-1:0] idx_q, idx_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [W-1:0]     min_q, min_d;
    logic [W-1:0]     max_q, max_d;
    logic [W-1:0]     min_o_q, min_o_d;
    logic [W-1:0]     max_o_q, max_o_d;
    logic [W-1:0]     media_q, media_d;
    logic             out_v_q, out_v_d;
    logic             accept, drop;
    logic [SW-1:0]    dato_ext, acc_sum;
    logic [W-1:0]     acc_min, acc_max;
`ifdef RITARDO_STAT_DROP_EN
    logic [7:0]       drop_cnt_q, drop_cnt_d;
`else
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        min_d    = min_q;
        max_d    = max_q;
        min_o_d  = min_o_q;
        max_o_d  = max_o_q;
        media_d  = media_q;
        out_v_d  = out_v_q;
        accept   = 1'b0;
        drop     = 1'b0;
        dato_ext = {{LOG_N{1'b0}}, dato};

        // Sample index 0 restarts the running statistics instead of folding into them.
        if (idx_q == '0) begin
            acc_sum = dato_ext;
            acc_min = dato;
            acc_max = dato;
        end else begin
            acc_sum = sum_q + dato_ext;
            acc_min = (dato < min_q) ? dato : min_q;
            acc_max = (dato > max_q) ? dato : max_q;
        end

        case (state_q)
            S_ACC: begin
                if (dato_v) accept = 1'b1;
            end
            default: begin
                if (ack) begin
                    out_v_d = 1'b0;
                    state_d = S_ACC;
                    if (dato_v) accept = 1'b1;
                end else if (dato_v) begin
                    drop = 1'b1;
                end
            end
        endcase

        if (accept) begin
            sum_d = acc_sum;
            min_d = acc_min;
            max_d = acc_max;
            idx_d = idx_q + LOG_N'(1);
            if (idx_q == LAST) begin
                min_o_d = acc_min;
                max_o_d = acc_max;
                media_d = acc_sum[SW-1:LOG_N];
                out_v_d = 1'b1;
                idx_d   = '0;
                state_d = S_OUT;
            end
        end

`ifdef RITARDO_STAT_DROP_EN
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`else
        ovf_d = ovf_q | drop;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_ACC;
            idx_q   <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            min_o_q <= '0;
            max_o_q <= '0;
            media_q <= '0;
            out_v_q <= 1'b0;
`ifdef RITARDO_STAT_DROP_EN
            drop_cnt_q <= '0;
`else
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            min_o_q <= min_o_d;
            max_o_q <= max_o_d;
            media_q <= media_d;
            out_v_q <= out_v_d;
`ifdef RITARDO_STAT_DROP_EN
            drop_cnt_q <= drop_cnt_d;
`else
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign min_o   = min_o_q;
    assign max_o   = max_o_q;
    assign media_o = media_q;
    assign out_v   = out_v_q;
`ifdef RITARDO_STAT_DROP_EN
    assign drop_cnt = drop_cnt_q;
    assign ovf      = (drop_cnt_q != 8'd0);
`else
    assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_ritardo_stat.sv
// Directed scoreboard bench for ritardo_stat: inputs driven and outputs sampled on the falling edge.
// Build with RITARDO_STAT_DROP_EN defined to also exercise the drop counter.
module tb_ritardo_stat;

    logic       clock;
    logic       reset;
    logic [7:0] dato;
    logic       dato_v;
    logic [7:0] min_o, max_o, media_o;
    logic       out_v;
    logic       ack;
    logic       ovf;
`ifdef RITARDO_STAT_DROP_EN
    logic [7:0] drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, written from the spec's behaviour, not from the RTL.
    logic [23:0] exp_q[$];
    int          m_cnt;
    int          m_sum;
    int          m_min;
    int          m_max;
    bit          m_out;
    bit          m_ovf;
    int          m_drops;
    logic [23:0] last_res;

    ritardo_stat dut (
        .clock   (clock),
        .reset   (reset),
        .dato    (dato),
        .dato_v  (dato_v),
        .min_o   (min_o),
        .max_o   (max_o),
        .media_o (media_o),
        .out_v   (out_v),
        .ack     (ack),
`ifdef RITARDO_STAT_DROP_EN
        .drop_cnt(drop_cnt),
`endif
        .ovf     (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_sum = 0; m_min = 0; m_max = 0;
        m_out = 0; m_ovf = 0; m_drops = 0;
        exp_q.delete();
    endtask

    // Called at a falling edge; holds the strobe for one rising edge.
    task automatic apply_stimulus(input int v, input bit a);
        dato   = 8'(v);
        dato_v = 1'b1;
        ack    = a;
        if (m_out && !a) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
        end else begin
            m_out = 0;
            if (m_cnt == 0) begin
                m_sum = v; m_min = v; m_max = v;
            end else begin
                m_sum += v;
                if (v < m_min) m_min = v;
                if (v > m_max) m_max = v;
            end
            m_cnt++;
            if (m_cnt == 8) begin
                exp_q.push_back({8'(m_min), 8'(m_max), 8'(m_sum / 8)});
                m_cnt = 0;
                m_out = 1;
            end
        end
        @(negedge clock);
        dato_v = 1'b0;
        ack    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        if (m_out) m_out = 0;
        @(negedge clock);
        ack = 1'b0;
    endtask

    // Bounded wait for out_v, then pop the scoreboard and compare.
    task automatic wait_result(input string tag);
        int k;
        logic [23:0] e;
        k = 0;
        while (out_v !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (out_v !== 1'b1) begin
            check_output({tag, "_timeout"}, 0, 1);
        end else if (exp_q.size() == 0) begin
            check_output({tag, "_unexpected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            last_res = e;
            check_output({tag, "_min"},   int'(min_o),   int'(e[23:16]));
            check_output({tag, "_max"},   int'(max_o),   int'(e[15:8]));
            check_output({tag, "_media"}, int'(media_o), int'(e[7:0]));
        end
    endtask

    initial begin
        int t6_vals[8];
        int t6_gaps[8];
        reset = 1'b1; dato = '0; dato_v = 1'b0; ack = 1'b0;
        model_reset();
        #1;
        check_output("rst_out_v", int'(out_v), 0);
        check_output("rst_min",   int'(min_o), 0);
        check_output("rst_max",   int'(max_o), 0);
        check_output("rst_media", int'(media_o), 0);
        check_output("rst_ovf",   int'(ovf), 0);
        idle(2);
        reset = 1'b0;
        idle(1);

        $display("[TB] test 1: ascending window");
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(i * 10, 1'b0);
            if (i == 7) check_output("t1_out_v_before_last", int'(out_v), 0);
        end
        check_output("t1_latency_out_v", int'(out_v), 1);
        wait_result("t1");
        check_output("t1_min_const", int'(min_o), 10);
        check_output("t1_media_const", int'(media_o), 45);

        $display("[TB] test 3: hold without ack, drops");
        for (int i = 0; i < 20; i++) begin
            if (i == 3 || i == 9 || i == 15) apply_stimulus(99, 1'b0);
            else idle(1);
        end
        check_output("t3_out_v_held", int'(out_v), 1);
        check_output("t3_min_held",   int'(min_o),   int'(last_res[23:16]));
        check_output("t3_max_held",   int'(max_o),   int'(last_res[15:8]));
        check_output("t3_media_held", int'(media_o), int'(last_res[7:0]));
        check_output("t3_ovf", int'(ovf), int'(m_ovf));
`ifdef RITARDO_STAT_DROP_EN
        check_output("t3_drop_cnt", int'(drop_cnt), m_drops);
`endif

        $display("[TB] test 4: simultaneous ack and strobe");
        apply_stimulus(5, 1'b1);
        check_output("t4_out_v_cleared", int'(out_v), 0);
        for (int i = 0; i < 7; i++) apply_stimulus(5, 1'b0);
        wait_result("t4");
        do_ack();
        check_output("t4_out_v_after_ack", int'(out_v), 0);

        $display("[TB] test 2: truncation without wrap");
        for (int i = 0; i < 7; i++) apply_stimulus(255, 1'b0);
        apply_stimulus(1, 1'b0);
        wait_result("t2");
        do_ack();

        $display("[TB] test 6: gaps between strobes, stray ack ignored");
        t6_vals = '{3, 200, 17, 99, 0, 128, 64, 250};
        t6_gaps = '{0, 3, 1, 2, 0, 3, 1, 0};
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(t6_vals[i], 1'b0);
            if (i < 7) begin
                if (i == 2) do_ack();
                idle(t6_gaps[i]);
                check_output("t6_no_early_out_v", int'(out_v), 0);
            end
        end
        wait_result("t6");
        do_ack();

        $display("[TB] test 5: reset mid-window");
        for (int i = 0; i < 4; i++) apply_stimulus(200, 1'b0);
        reset = 1'b1;
        #1;
        check_output("t5_async_ovf", int'(ovf), 0);
        check_output("t5_async_out_v", int'(out_v), 0);
        model_reset();
        idle(2);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 8; i++) apply_stimulus(7, 1'b0);
        wait_result("t5");
        check_output("t5_ovf", int'(ovf), 0);
`ifdef RITARDO_STAT_DROP_EN
        check_output("t5_drop_cnt", int'(drop_cnt), 0);
`endif
        do_ack();
        check_output("end_scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
